// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. It owns the PC, issues instruction reads, and
//   loads the IF/ID pipeline register. A one-entry skid buffer keeps a word
//   that returns while ID is stalled, so the read never has to be reissued.
//   Downstream redirects (flush) and a retired HALT override normal fetching.
//
// Ports
//   CLK            in   1   clock, rising edge
//   nRST           in   1   asynchronous reset, active low
//   ihit           in   1   imemload is valid for imemaddr this cycle
//   imemload       in   32  instruction word from instruction memory
//   stall          in   1   ID cannot accept a new IF/ID entry
//   flush          in   1   branch/jump redirect resolved downstream
//   redirect_addr  in   32  redirect target, used when flush=1
//   halt           in   1   HALT retired; fetch stops until reset
//   iREN           out  1   instruction read request
//   imemaddr       out  32  read address (always the PC)
//   instr_IF_ID    out  32  instruction word into IF/ID
//   npc_IF_ID      out  32  address of that instruction + 4
//   valid_IF_ID    out  1   1 = real instruction, 0 = bubble
//   fetch_cnt      out  32  instructions delivered with valid_IF_ID=1
//
// State   | meaning
// --------+------------------------------------------------------------------
// FETCH   | PC is being read; a returning word goes to IF/ID or the skid buffer
// HOLD    | skid buffer holds a word waiting for ID to release its stall
// HALTED  | HALT retired; no reads, all inputs ignored until reset
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] redirect_addr,
   input  logic        halt,
   output logic        iREN,
   output logic [31:0] imemaddr,
   output logic [31:0] instr_IF_ID,
   output logic [31:0] npc_IF_ID,
   output logic        valid_IF_ID,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } state_t;

   // The PC is kept word aligned even if PC_INIT carries stray low bits.
   localparam logic [31:0] PC_RESET = {PC_INIT[31:2], 2'b00};

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] pc_plus4;
   logic [31:0] instr_nxt;
   logic [31:0] npc_nxt;
   logic        valid_nxt;
   logic [31:0] cnt_nxt;
   logic [31:0] skid_instr, skid_instr_nxt;
   logic [31:0] skid_npc, skid_npc_nxt;

   // Redirect targets are forced to a word boundary, so the low bits are dropped.
   logic        unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_addr[1:0];

   // Natural 32-bit overflow gives the required modulo-2^32 wrap.
   assign pc_plus4 = pc + 32'd4;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state       <= FETCH;
         pc          <= PC_RESET;
         instr_IF_ID <= '0;
         npc_IF_ID   <= '0;
         valid_IF_ID <= 1'b0;
         fetch_cnt   <= '0;
         skid_instr  <= '0;
         skid_npc    <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         instr_IF_ID <= instr_nxt;
         npc_IF_ID   <= npc_nxt;
         valid_IF_ID <= valid_nxt;
         fetch_cnt   <= cnt_nxt;
         skid_instr  <= skid_instr_nxt;
         skid_npc    <= skid_npc_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      instr_nxt      = instr_IF_ID;
      npc_nxt        = npc_IF_ID;
      valid_nxt      = valid_IF_ID;
      cnt_nxt        = fetch_cnt;
      skid_instr_nxt = skid_instr;
      skid_npc_nxt   = skid_npc;

      if (state == HALTED) begin
         state_nxt = HALTED;
      end else if (halt) begin
         // HALT wins over a coincident redirect; the PC freezes where it is.
         state_nxt      = HALTED;
         valid_nxt      = 1'b0;
         skid_instr_nxt = '0;
         skid_npc_nxt   = '0;
      end else if (flush) begin
         // Redirect wins over any returning word and any buffered word.
         state_nxt      = FETCH;
         pc_nxt         = {redirect_addr[31:2], 2'b00};
         instr_nxt      = '0;
         valid_nxt      = 1'b0;
         skid_instr_nxt = '0;
         skid_npc_nxt   = '0;
      end else begin
         unique case (state)
            FETCH: begin
               if (ihit && !stall) begin
                  instr_nxt = imemload;
                  npc_nxt   = pc_plus4;
                  valid_nxt = 1'b1;
                  pc_nxt    = pc_plus4;
                  cnt_nxt   = fetch_cnt + 32'd1;
               end else if (ihit && stall) begin
                  // PC advances only when the word actually leaves the buffer.
                  skid_instr_nxt = imemload;
                  skid_npc_nxt   = pc_plus4;
                  state_nxt      = HOLD;
               end else if (!stall) begin
                  instr_nxt = '0;
                  valid_nxt = 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  instr_nxt      = skid_instr;
                  npc_nxt        = skid_npc;
                  valid_nxt      = 1'b1;
                  pc_nxt         = pc_plus4;
                  cnt_nxt        = fetch_cnt + 32'd1;
                  skid_instr_nxt = '0;
                  skid_npc_nxt   = '0;
                  state_nxt      = FETCH;
               end
            end
            default: begin
               state_nxt = HALTED;
            end
         endcase
      end
   end

   assign iREN     = (state == FETCH);
   assign imemaddr = pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_INIT, default 32'h00000000, SHALL be the PC value loaded on reset.
REQ-002 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 nRST  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 ihit  in  1  SHALL indicate imemload is valid for the current imemaddr this cycle.
REQ-005 imemload  in  32  SHALL carry the instruction word returned by instruction memory.
REQ-006 stall  in  1  SHALL indicate the ID stage cannot accept a new IF/ID entry this cycle.
REQ-007 flush  in  1  SHALL indicate a branch/jump redirect resolved downstream.
REQ-008 redirect_addr  in  32  SHALL be the target PC when flush=1.
REQ-009 halt  in  1  SHALL indicate a HALT has retired; fetching stops permanently.
REQ-010 iREN  out  1  SHALL request an instruction read.
REQ-011 imemaddr  out  32  SHALL be the read address, always equal to PC.
REQ-012 instr_IF_ID  out  32  SHALL be the instruction word driven into the IF/ID register.
REQ-013 npc_IF_ID  out  32  SHALL be the fetched instruction's address + 4.
REQ-014 valid_IF_ID  out  1  SHALL mark instr_IF_ID as a real instruction (0 = bubble).
REQ-015 fetch_cnt  out  32  SHALL count instructions delivered with valid_IF_ID=1.

Function
REQ-016 States SHALL be FETCH, HOLD, HALTED; reset state FETCH.
REQ-017 iREN SHALL be 1 in FETCH and 0 in HOLD and HALTED.
REQ-018 FETCH, ihit=1, stall=0: instr_IF_ID<=imemload, npc_IF_ID<=PC+4, valid_IF_ID<=1, PC<=PC+4, fetch_cnt+=1, remain FETCH.
REQ-019 FETCH, ihit=1, stall=1: imemload and PC+4 SHALL be captured in a one-entry skid buffer, IF/ID outputs held, PC unchanged, next state HOLD.
REQ-020 FETCH, ihit=0, stall=0: valid_IF_ID<=0, instr_IF_ID<=0, PC unchanged (bubble inserted).
REQ-021 Any state except HALTED, stall=1, no other event: IF/ID outputs SHALL hold their values.
REQ-022 HOLD, stall=0: skid buffer SHALL transfer to IF/ID with valid_IF_ID<=1, PC<=PC+4, fetch_cnt+=1, next state FETCH; HOLD, stall=1: remain HOLD.
REQ-023 Latency: an instruction SHALL appear on IF/ID outputs the cycle after ihit when stall=0.
REQ-024 flush=1 SHALL take priority over ihit, stall and HOLD: PC<={redirect_addr[31:2],2'b00}, valid_IF_ID<=0, instr_IF_ID<=0, skid buffer discarded, next state FETCH; a coincident ihit word SHALL be dropped and not counted.
REQ-025 halt=1 SHALL take priority over flush: next state HALTED, valid_IF_ID<=0, PC held.
REQ-026 HALTED SHALL persist until nRST; ihit, stall, flush ignored; iREN=0.
REQ-027 PC+4 and fetch_cnt SHALL wrap modulo 2^32 (32'hFFFFFFFC+4 = 0).
REQ-028 PC[1:0] SHALL always be 2'b00.

Reset
REQ-029 nRST=0 SHALL immediately, without a clock edge, force PC=PC_INIT, state FETCH, instr_IF_ID=0, npc_IF_ID=0, valid_IF_ID=0, fetch_cnt=0, skid buffer empty.
REQ-030 Reset asserted mid-HOLD or in HALTED SHALL discard the buffered instruction; first request after release SHALL be to PC_INIT.

Verification
REQ-031 Reset, ihit=1 every cycle, imemload=32'h8C220004, stall=0 -> imemaddr 0,4,8; valid_IF_ID=1 from cycle 2; npc_IF_ID=4,8,12; fetch_cnt=3 after 3 hits.
REQ-032 PC=0x10, ihit=1, stall=1 for 3 cycles, then stall=0 -> HOLD, iREN=0, IF/ID held; on release instr delivered with npc=0x14, PC=0x14, fetch_cnt +1 exactly once.
REQ-033 ihit=1 and flush=1 with redirect_addr=0x00000403 same cycle -> PC=0x400, valid_IF_ID=0, fetch_cnt unchanged, next imemaddr=0x400.
REQ-034 halt=1 while flush=1 and ihit=1 -> HALTED, iREN=0, valid_IF_ID=0; later flush/ihit cause no change until nRST.
REQ-035 PC=32'hFFFFFFFC, ihit=1, stall=0 -> npc_IF_ID=0, next imemaddr=0.
REQ-036 nRST pulled low asynchronously mid-cycle in HOLD -> outputs zero before next CLK edge; after release imemaddr=PC_INIT, buffered word never appears.
